// File: rtl/seven_seg_decoder.sv
// Recovers hex digits from an active-low 7-segment bus: debounces the bus, decodes each newly
// stable pattern and hands it out through a single-entry valid/ready buffer.
module seven_seg_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] seg,
    input  logic       ready,
    output logic       valid,
    output logic [3:0] digit,
    output logic       blank,
    output logic       err,
    output logic       overrun
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_ARM = CW'(STABLE_CYCLES - 1);
    localparam logic [6:0]    SEG_BLANK = 7'h7F;

    logic [6:0]    seg_q, seg_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [6:0]    last_acc_q, last_acc_d;

    logic          pend_valid_q, pend_valid_d;
    logic [3:0]    pend_digit_q, pend_digit_d;
    logic          pend_blank_q, pend_blank_d;
    logic          pend_err_q, pend_err_d;

    logic          valid_q, valid_d;
    logic [3:0]    digit_q, digit_d;
    logic          blank_q, blank_d;
    logic          err_q, err_d;
    logic          overrun_q, overrun_d;

    logic          accept;
    logic [3:0]    dec_digit;
    logic          dec_blank;
    logic          dec_err;

    always_comb begin
        dec_digit = 4'h0;
        dec_blank = 1'b0;
        dec_err   = 1'b0;
        case (seg_q)
            7'h40:   dec_digit = 4'h0;
            7'h79:   dec_digit = 4'h1;
            7'h24:   dec_digit = 4'h2;
            7'h30:   dec_digit = 4'h3;
            7'h19:   dec_digit = 4'h4;
            7'h12:   dec_digit = 4'h5;
            7'h02:   dec_digit = 4'h6;
            7'h78:   dec_digit = 4'h7;
            7'h00:   dec_digit = 4'h8;
            7'h18:   dec_digit = 4'h9;
            7'h08:   dec_digit = 4'hA;
            7'h03:   dec_digit = 4'hB;
            7'h46:   dec_digit = 4'hC;
            7'h21:   dec_digit = 4'hD;
            7'h06:   dec_digit = 4'hE;
            7'h0E:   dec_digit = 4'hF;
            7'h7F:   dec_blank = 1'b1;
            default: dec_err   = 1'b1;
        endcase
    end

    // Glitch filter: a pattern is accepted on the edge its run length first reaches the
    // threshold, and only if it differs from the last accepted pattern.
    always_comb begin
        seg_d      = seg;
        last_acc_d = last_acc_q;
        if (seg != seg_q) begin
            cnt_d = CW'(1);
        end else if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
        accept = (cnt_q == CNT_ARM) && (cnt_d == CNT_MAX) && (seg_q != last_acc_q);
        if (accept) begin
            last_acc_d = seg_q;
        end
    end

    always_comb begin
        pend_valid_d = accept;
        pend_digit_d = dec_digit;
        pend_blank_d = dec_blank;
        pend_err_d   = dec_err;
    end

    // Output buffer: a pending result refills a slot that is empty or being drained this
    // cycle; otherwise it is dropped and flagged.
    always_comb begin
        valid_d   = valid_q;
        digit_d   = digit_q;
        blank_d   = blank_q;
        err_d     = err_q;
        overrun_d = overrun_q;
        if (pend_valid_q) begin
            if (!valid_q || ready) begin
                valid_d = 1'b1;
                digit_d = pend_digit_q;
                blank_d = pend_blank_q;
                err_d   = pend_err_q;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q        <= SEG_BLANK;
            cnt_q        <= '0;
            last_acc_q   <= SEG_BLANK;
            pend_valid_q <= 1'b0;
            pend_digit_q <= 4'h0;
            pend_blank_q <= 1'b0;
            pend_err_q   <= 1'b0;
            valid_q      <= 1'b0;
            digit_q      <= 4'h0;
            blank_q      <= 1'b0;
            err_q        <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            seg_q        <= seg_d;
            cnt_q        <= cnt_d;
            last_acc_q   <= last_acc_d;
            pend_valid_q <= pend_valid_d;
            pend_digit_q <= pend_digit_d;
            pend_blank_q <= pend_blank_d;
            pend_err_q   <= pend_err_d;
            valid_q      <= valid_d;
            digit_q      <= digit_d;
            blank_q      <= blank_d;
            err_q        <= err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign valid   = valid_q;
    assign digit   = digit_q;
    assign blank   = blank_q;
    assign err     = err_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_seven_seg_decoder.sv
// Self-checking bench for seven_seg_decoder: directed scenarios followed by randomized
// segment patterns, all compared each cycle against a run-length reference model.
module tb_seven_seg_decoder;

    localparam int STABLE = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] seg = 7'h7F;
    logic       ready = 1'b1;
    logic       valid;
    logic [3:0] digit;
    logic       blank;
    logic       err;
    logic       overrun;

    int tests_run = 0;
    int tests_failed = 0;

    logic [6:0] glyphs [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model state: current run pattern and its length, last accepted pattern,
    // one result in flight toward the buffer, and the expected buffer contents.
    logic [6:0] m_pat = 7'h7F;
    int         m_run = 0;
    logic [6:0] m_last = 7'h7F;
    bit         m_pend = 0;
    logic [3:0] m_pd = 4'h0;
    logic       m_pb = 1'b0;
    logic       m_pe = 1'b0;
    logic       exp_valid = 1'b0;
    logic [3:0] exp_digit = 4'h0;
    logic       exp_blank = 1'b0;
    logic       exp_err = 1'b0;
    logic       exp_over = 1'b0;

    int         obs_count = 0;
    logic [3:0] obs_digit = 4'h0;
    logic       obs_blank = 1'b0;
    logic       obs_err = 1'b0;

    seven_seg_decoder #(.STABLE_CYCLES(STABLE)) dut (
        .clk     (clk),
        .reset   (reset),
        .seg     (seg),
        .ready   (ready),
        .valid   (valid),
        .digit   (digit),
        .blank   (blank),
        .err     (err),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    task automatic decodeModel(input logic [6:0] p, output logic [3:0] d, output logic b, output logic e);
        d = 4'h0;
        b = (p == 7'h7F);
        e = !b;
        for (int i = 0; i < 16; i++) begin
            if (glyphs[i] == p) begin
                d = i[3:0];
                e = 1'b0;
            end
        end
    endtask

    task automatic modelStep(input logic [6:0] s, input logic r, input logic rst);
        bit new_evt;
        if (rst) begin
            m_pat = 7'h7F; m_run = 0; m_last = 7'h7F; m_pend = 0;
            exp_valid = 1'b0; exp_digit = 4'h0; exp_blank = 1'b0; exp_err = 1'b0; exp_over = 1'b0;
        end else begin
            if (m_pend) begin
                if (!exp_valid || r) begin
                    exp_valid = 1'b1; exp_digit = m_pd; exp_blank = m_pb; exp_err = m_pe;
                end else begin
                    exp_over = 1'b1;
                end
            end else if (exp_valid && r) begin
                exp_valid = 1'b0;
            end
            new_evt = 0;
            if (s == m_pat) begin
                m_run++;
            end else begin
                m_pat = s;
                m_run = 1;
            end
            if (m_run == STABLE && m_pat != m_last) begin
                new_evt = 1;
                m_last = m_pat;
                decodeModel(m_pat, m_pd, m_pb, m_pe);
            end
            m_pend = new_evt;
        end
    endtask

    task automatic checkValue(input string tag, input int observed, input int expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput();
        tests_run++;
        assert (valid === exp_valid) else begin
            tests_failed++;
            $error("[TB] FAIL valid @%0t: observed %0b expected %0b", $time, valid, exp_valid);
        end
        tests_run++;
        assert (overrun === exp_over) else begin
            tests_failed++;
            $error("[TB] FAIL overrun @%0t: observed %0b expected %0b", $time, overrun, exp_over);
        end
        if (exp_valid) begin
            tests_run++;
            assert ({digit, blank, err} === {exp_digit, exp_blank, exp_err}) else begin
                tests_failed++;
                $error("[TB] FAIL result @%0t: observed d=%0h b=%0b e=%0b expected d=%0h b=%0b e=%0b",
                       $time, digit, blank, err, exp_digit, exp_blank, exp_err);
            end
        end
    endtask

    // Drives the inputs for n edges, logging every handshake the DUT completes.
    task automatic applyStimulus(input logic [6:0] s, input logic r, input logic rst, input int n);
        for (int i = 0; i < n; i++) begin
            seg = s;
            ready = r;
            reset = rst;
            if (valid && r && !rst) begin
                obs_count++;
                obs_digit = digit;
                obs_blank = blank;
                obs_err = err;
            end
            @(posedge clk);
            modelStep(s, r, rst);
            #1;
            checkOutput();
        end
    endtask

    initial begin
        logic [6:0] p;
        int base;

        // 1: reset state, then latency of the first result
        applyStimulus(7'h40, 1'b1, 1'b1, 2);
        checkValue("reset_valid", int'(valid), 0);
        checkValue("reset_overrun", int'(overrun), 0);
        applyStimulus(7'h40, 1'b1, 1'b0, 4);
        checkValue("t1_valid_before", int'(valid), 0);
        applyStimulus(7'h40, 1'b1, 1'b0, 1);
        checkValue("t1_valid", int'(valid), 1);
        checkValue("t1_result", int'({digit, blank, err}), 0);
        applyStimulus(7'h40, 1'b1, 1'b0, 1);
        checkValue("t1_pulse", int'(valid), 0);

        // 2: short burst of 2 is filtered, 3 is reported once
        base = obs_count;
        applyStimulus(7'h24, 1'b1, 1'b0, 3);
        applyStimulus(7'h30, 1'b1, 1'b0, 6);
        checkValue("t2_count", obs_count - base, 1);
        checkValue("t2_digit", int'(obs_digit), 3);

        // 3: illegal glyph then blank
        applyStimulus(7'h7E, 1'b1, 1'b0, 5);
        checkValue("t3_err", int'({valid, digit, blank, err}), 'b1_0000_0_1);
        applyStimulus(7'h7E, 1'b1, 1'b0, 1);
        applyStimulus(7'h7F, 1'b1, 1'b0, 5);
        checkValue("t3_blank", int'({valid, digit, blank, err}), 'b1_0000_1_0);
        applyStimulus(7'h7F, 1'b1, 1'b0, 1);

        // 4: stalled consumer drops the second result
        base = obs_count;
        applyStimulus(7'h79, 1'b0, 1'b0, 6);
        applyStimulus(7'h24, 1'b0, 1'b0, 6);
        checkValue("t4_held", int'({valid, digit}), 'b1_0001);
        checkValue("t4_overrun", int'(overrun), 1);
        applyStimulus(7'h24, 1'b1, 1'b0, 1);
        checkValue("t4_drained", int'(valid), 0);
        applyStimulus(7'h24, 1'b1, 1'b0, 6);
        checkValue("t4_count", obs_count - base, 1);

        // 5: glitch does not re-report; blank re-arms
        base = obs_count;
        applyStimulus(7'h08, 1'b1, 1'b0, 6);
        applyStimulus(7'h00, 1'b1, 1'b0, 2);
        applyStimulus(7'h08, 1'b1, 1'b0, 6);
        checkValue("t5_once", obs_count - base, 1);
        applyStimulus(7'h7F, 1'b1, 1'b0, 6);
        checkValue("t5_blank", int'(obs_blank), 1);
        applyStimulus(7'h08, 1'b1, 1'b0, 6);
        checkValue("t5_count", obs_count - base, 3);
        checkValue("t5_digit", int'(obs_digit), 'hA);

        // 6: reset mid-filter discards the partial count and clears overrun
        applyStimulus(7'h12, 1'b1, 1'b0, 3);
        applyStimulus(7'h12, 1'b1, 1'b1, 1);
        applyStimulus(7'h12, 1'b1, 1'b0, 4);
        checkValue("t6_early", int'(valid), 0);
        applyStimulus(7'h12, 1'b1, 1'b0, 1);
        checkValue("t6_result", int'({valid, digit, overrun}), 'b1_0101_0);

        // Randomized patterns, durations, back-pressure and occasional resets
        for (int k = 0; k < 120; k++) begin
            case ($urandom_range(0, 5))
                0:       p = 7'h7F;
                1:       p = 7'($urandom);
                default: p = glyphs[$urandom_range(0, 15)];
            endcase
            if ($urandom_range(0, 19) == 0) begin
                applyStimulus(p, 1'b1, 1'b1, 1);
            end
            for (int c = $urandom_range(1, 7); c > 0; c--) begin
                applyStimulus(p, ($urandom_range(0, 3) != 0), 1'b0, 1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
